// File: rtl/tt_mem_bridge_if.sv
// Core-side memory request and 8-bit pin bus of the Tiny Tapeout memory bridge.
// The slave modport is the bridge itself; the master modport is the core/pad environment.
interface tt_mem_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_done;
    logic              core_err;
    logic              busy;
    logic [7:0]        pin_in;
    logic              pin_ack;
    logic [7:0]        pin_out;
    logic [3:0]        pin_ctl;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, pin_in, pin_ack,
        output core_rdata, core_done, core_err, busy, pin_out, pin_ctl
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, pin_in, pin_ack,
        input  core_rdata, core_done, core_err, busy, pin_out, pin_ctl
    );
endinterface

// File: rtl/tt_mem_bridge.sv
// Serialises a core memory request onto 8-bit pins, LSB byte first: address, then write or read data.
// Latency with pin_ack high: accept edge + AB + DB byte cycles + one DONE cycle; a stalled byte aborts after WAIT_MAX cycles.
module tt_mem_bridge #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    tt_mem_bridge_if.slave bus
);
    localparam int AB   = (ADDR_W + 7) / 8;
    localparam int DB   = (DATA_W + 7) / 8;
    localparam int AW_P = AB * 8;
    localparam int DW_P = DB * 8;
    localparam int CW   = $clog2(WAIT_MAX + 1);

    localparam logic [1:0]    A_LAST   = 2'(AB - 1);
    localparam logic [1:0]    D_LAST   = 2'(DB - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [1:0]        r_idx;
    logic [CW-1:0]     r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DW_P-1:0]   r_shadow;
    logic [DATA_W-1:0] r_rdata;
    logic              r_done;
    logic              r_err;

    logic [AW_P-1:0]   w_addr_pad;
    logic [DW_P-1:0]   w_wdata_pad;
    logic [DW_P-1:0]   w_shadow_nxt;
    logic [7:0]        w_pin_out;
    logic [1:0]        w_phase;
    logic              w_valid;
    logic              w_last;

    assign w_addr_pad  = AW_P'(r_addr);
    assign w_wdata_pad = DW_P'(r_wdata);
    assign w_last      = (r_state == S_ADDR) ? (r_idx == A_LAST) : (r_idx == D_LAST);

    // Read bytes land in a byte-granular shadow; bits above DATA_W are dropped when it is published.
    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int i = 0; i < DB; i++) begin
            if (r_idx == 2'(i)) begin
                w_shadow_nxt[i*8 +: 8] = bus.pin_in;
            end
        end
    end

    always_comb begin
        w_pin_out = 8'h00;
        w_phase   = 2'b00;
        case (r_state)
            S_ADDR: begin
                w_pin_out = 8'(w_addr_pad >> {r_idx, 3'b000});
                w_phase   = 2'b01;
            end
            S_WDATA: begin
                w_pin_out = 8'(w_wdata_pad >> {r_idx, 3'b000});
                w_phase   = 2'b10;
            end
            S_RDATA: begin
                w_phase   = 2'b11;
            end
            default: begin
                w_pin_out = 8'h00;
                w_phase   = 2'b00;
            end
        endcase
    end

    assign w_valid = (w_phase != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_shadow <= '0;
            r_rdata  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.core_req) begin
                        r_we    <= bus.core_we;
                        r_addr  <= bus.core_addr;
                        r_wdata <= bus.core_wdata;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR, S_WDATA, S_RDATA: begin
                    // An ack always completes the byte, even on the last allowed wait cycle.
                    if (bus.pin_ack) begin
                        r_cnt <= '0;
                        if (r_state == S_RDATA) begin
                            r_shadow <= w_shadow_nxt;
                        end
                        if (w_last) begin
                            r_idx <= '0;
                            case (r_state)
                                S_ADDR:  r_state <= r_we ? S_WDATA : S_RDATA;
                                S_RDATA: begin
                                    r_rdata <= w_shadow_nxt[DATA_W-1:0];
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end
                                default: begin
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end
                            endcase
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.core_rdata = r_rdata;
    assign bus.core_done  = r_done;
    assign bus.core_err   = r_err;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.pin_out    = w_pin_out;
    assign bus.pin_ctl    = {w_phase, w_valid & r_we, w_valid};
endmodule

// File: doc/tt_mem_bridge.md
Name: tt_mem_bridge

Overview:
Parametrised successor to the direct SoC-to-pin mapping in the Tiny Tapeout top level. Serialises a core-side memory request onto the 8-bit dedicated pins, one byte per handshake. Address can be ADDR_W bits wide and data DATA_W bits wide, rather than being truncated to 8 bits. Sits between the MIPS core's memory port and ui_in/uo_out/uio; adds read/write phases, a byte handshake and a timeout.

Parameters:
ADDR_W, 16, core address width (1..32)
DATA_W, 32, core data width (1..32)
WAIT_MAX, 255, max cycles a byte waits for pin_ack before error (≥1)
(derived: AB = ceil(ADDR_W/8), DB = ceil(DATA_W/8))

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
core_req  in  1  request; sampled only in IDLE
core_we  in  1  1 = write, 0 = read; latched with core_req
core_addr  in  ADDR_W  address; latched with core_req
core_wdata  in  DATA_W  write data; latched with core_req
core_rdata  out  DATA_W  read data; updated only on successful read
core_done  out  1  one-cycle pulse, transfer complete
core_err  out  1  one-cycle pulse, timeout abort
busy  out  1  high in every state except IDLE
pin_in  in  8  external byte (ui_in)
pin_ack  in  1  external byte acknowledge (uio_in bit)
pin_out  out  8  byte driven to pins (uo_out)
pin_ctl  out  4  [0] valid, [1] we, [3:2] phase: 00 idle, 01 addr, 10 wdata, 11 rdata

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, all outputs 0, including core_rdata. Byte index and timeout counter are cleared. Reset mid-transfer aborts at once with no done or err pulse.
- States: IDLE, ADDR, WDATA, RDATA, DONE, ERR.
- IDLE with core_req=1: latch we/addr/wdata, go to ADDR. core_req is ignored whenever busy=1.
- ADDR: pin_out = address byte[idx], LSB first. Bits above ADDR_W are zero.
- After the last address byte is acked: go to WDATA if we=1, else RDATA.
- WDATA: pin_out = wdata byte[idx], LSB first, zero-padded.
- RDATA: pin_out = 0. On ack, pin_in is captured into a shadow byte[idx]; bits above DATA_W are discarded.
- pin_ctl in ADDR/WDATA/RDATA: valid=1, we = latched we, phase per state. In IDLE/DONE/ERR pin_ctl = 0.
- Byte handshake: a byte completes on any edge where valid=1 and pin_ack=1. idx then increments and the timeout counter clears. No dead cycle between bytes, so pin_ack held high moves one byte per cycle. idx resets to 0 on each phase change.
- Timeout: the counter increments on each cycle of the current byte with pin_ack=0. If it reaches WAIT_MAX without an ack, go to ERR. A byte therefore waits at most WAIT_MAX cycles. An ack in the same cycle the counter reaches WAIT_MAX wins.
- DONE (1 cycle): core_done=1. For a read, core_rdata takes the shadow value in this cycle. Then go to IDLE.
- ERR (1 cycle): core_err=1, core_rdata unchanged. Then go to IDLE.
- Latency with pin_ack tied high: accept edge, then AB (+DB) byte cycles, then the DONE cycle. A new request can be accepted in the cycle after DONE.
- core_done and core_err are never high together.

Test Plan:
- Write, defaults, pin_ack=1, addr=0x1234, wdata=0xDEADBEEF -> pin_out sequence 34,12,EF,BE,AD,DE. Phase sequence 01,01,10,10,10,10, we=1. core_done high exactly 7 cycles after the accept edge.
- Read, addr=0x00F0, pin_ack=1, pin_in sequence EF,BE,AD,DE during RDATA -> core_rdata=0xDEADBEEF in the DONE cycle. pin_out=00 during RDATA. core_rdata stays 0 before DONE.
- Stalled ack: pin_ack low 3 cycles on each byte -> each byte held stable for 4 cycles; transfer completes with correct data and no err.
- Timeout, WAIT_MAX=4, pin_ack=0 -> 4 cycles in ADDR byte 0, then ERR with core_err pulse. Previous core_rdata retained. Next request accepted normally.
- Odd widths, ADDR_W=12, DATA_W=12, read addr=0xABC, pin_in 0x34,0xF2 -> pin_out ADDR bytes BC,0A. core_rdata=0x234.
- Reset: rst_n low during WDATA byte 2 -> next cycle IDLE, all outputs 0, no done/err pulse. core_req held high during busy is not re-latched until IDLE.
